// File: rtl/ncf_voice_pkg.sv
// Shared types for the NCF voice allocator: FSM states, selection paths
// and the default note-number width.
package ncf_voice_pkg;

    localparam int NOTE_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_KILL = 2'd2,
        ST_TRIG = 2'd3
    } state_t;

    // How the selected voice is serviced once SCAN has chosen it
    typedef enum logic [1:0] {
        PATH_TRIG = 2'd0,   // gate straight up with a GATEchgd pulse
        PATH_KILL = 2'd1,   // one low cycle first, then TRIG
        PATH_OFF  = 2'd2,   // note-off: drop the gate
        PATH_DROP = 2'd3    // nothing to do
    } path_t;

endpackage

// File: rtl/ncf_lru_rank.sv
// Least-recently-triggered ranking for the voice bank. Rank 0 is the newest
// voice, NUM_VOICES-1 the oldest; the ranks always form a permutation.
module ncf_lru_rank #(
    parameter int NUM_VOICES = 4,
    localparam int IDX_W = $clog2(NUM_VOICES)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        touch,
    input  logic [IDX_W-1:0]            touch_idx,
    output logic [NUM_VOICES*IDX_W-1:0] rank_flat,
    output logic [IDX_W-1:0]            oldest_idx
);

    logic [IDX_W-1:0] rank [NUM_VOICES];
    logic [IDX_W-1:0] touch_rank;

    assign touch_rank = rank[touch_idx];

    // Touch moves a voice to rank 0 and ages every voice that was newer than it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                rank[v] <= IDX_W'(v);
            end
        end else if (touch) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (IDX_W'(v) == touch_idx) begin
                    rank[v] <= '0;
                end else if (rank[v] < touch_rank) begin
                    rank[v] <= rank[v] + 1'b1;
                end
            end
        end
    end

    // Flatten the ranks and locate the voice holding the oldest rank
    always_comb begin
        rank_flat  = '0;
        oldest_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            rank_flat[v*IDX_W +: IDX_W] = rank[v];
            if (rank[v] == IDX_W'(NUM_VOICES - 1)) begin
                oldest_idx = IDX_W'(v);
            end
        end
    end

endmodule

// File: rtl/ncf_voice_alloc.sv
// Polyphonic voice allocator: maps note-on/note-off commands onto a bank of
// ADSR voices and drives their GATE / GATEchgd inputs. A voice that must
// restart from a gated state gets one low gate cycle first, because the ADSR
// ignores GATEchgd while in SUSTAIN.
module ncf_voice_alloc
    import ncf_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = NOTE_W_DEF
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_on,
    input  logic [NOTE_W-1:0]            cmd_note,
    input  logic [NUM_VOICES-1:0]        env_idle,
    output logic [NUM_VOICES-1:0]        gate,
    output logic [NUM_VOICES-1:0]        gate_chgd,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic                         steal
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    state_t                      state;
    logic                        scan_ph;
    logic                        on_q;
    logic [NOTE_W-1:0]           note_q;
    logic [IDX_W-1:0]            sel_q;
    path_t                       path_q;
    logic                        steal_q;

    logic [IDX_W-1:0]            sel_c;
    path_t                       path_c;
    logic                        steal_c;

    logic [NUM_VOICES-1:0]       note_match;
    logic [NUM_VOICES-1:0]       c_match_on;
    logic [NUM_VOICES-1:0]       c_match_off;
    logic [NUM_VOICES-1:0]       c_free;
    logic [NUM_VOICES-1:0]       c_rel;
    logic [IDX_W-1:0]            rel_idx;
    logic [IDX_W-1:0]            rel_rank;
    logic                        rel_found;

    logic                        touch;
    logic [NUM_VOICES*IDX_W-1:0] rank_flat;
    logic [IDX_W-1:0]            oldest_idx;

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_VOICES-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (m[v]) r = IDX_W'(v);
        end
        return r;
    endfunction

    assign cmd_ready = (state == ST_IDLE);

    // LRU is touched on the edge that enters TRIG, from SCAN or from KILL
    assign touch = (state == ST_KILL) ||
                   (state == ST_SCAN && scan_ph && path_q == PATH_TRIG);

    ncf_lru_rank #(
        .NUM_VOICES (NUM_VOICES)
    ) u_lru (
        .clock      (clock),
        .reset_n    (reset_n),
        .touch      (touch),
        .touch_idx  (sel_q),
        .rank_flat  (rank_flat),
        .oldest_idx (oldest_idx)
    );

    // Per-voice note comparison against the latched command
    always_comb begin
        note_match = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            note_match[v] = (voice_note[v*NOTE_W +: NOTE_W] == note_q);
        end
    end

    assign c_match_on  = note_match & gate;
    assign c_match_off = note_match & ~gate;
    assign c_free      = ~gate & env_idle;
    assign c_rel       = ~gate;

    // Oldest (highest-rank) voice among those already released
    always_comb begin
        rel_idx   = '0;
        rel_rank  = '0;
        rel_found = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (c_rel[v] && (!rel_found || rank_flat[v*IDX_W +: IDX_W] > rel_rank)) begin
                rel_idx   = IDX_W'(v);
                rel_rank  = rank_flat[v*IDX_W +: IDX_W];
                rel_found = 1'b1;
            end
        end
    end

    // Priority selection: retrigger, reuse, free idle, releasing, then steal
    always_comb begin
        sel_c   = '0;
        path_c  = PATH_DROP;
        steal_c = 1'b0;
        if (on_q) begin
            if (|c_match_on) begin
                sel_c  = lowest(c_match_on);
                path_c = PATH_KILL;
            end else if (|c_match_off) begin
                sel_c  = lowest(c_match_off);
                path_c = PATH_TRIG;
            end else if (|c_free) begin
                sel_c  = lowest(c_free);
                path_c = PATH_TRIG;
            end else if (|c_rel) begin
                sel_c  = rel_idx;
                path_c = PATH_TRIG;
            end else begin
                sel_c   = oldest_idx;
                path_c  = PATH_KILL;
                steal_c = 1'b1;
            end
        end else if (|c_match_on) begin
            sel_c  = lowest(c_match_on);
            path_c = PATH_OFF;
        end
    end

    // Command and selection capture; pure data, qualified by the FSM
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && cmd_valid) begin
            on_q   <= cmd_on;
            note_q <= cmd_note;
        end
        if (state == ST_SCAN && !scan_ph) begin
            sel_q   <= sel_c;
            path_q  <= path_c;
            steal_q <= steal_c;
        end
    end

    // Control FSM with registered gate, GATEchgd, note and steal outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            scan_ph    <= 1'b0;
            gate       <= '0;
            gate_chgd  <= '0;
            voice_note <= '0;
            steal      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        scan_ph <= 1'b0;
                        state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!scan_ph) begin
                        scan_ph <= 1'b1;
                    end else begin
                        scan_ph <= 1'b0;
                        case (path_q)
                            PATH_TRIG: begin
                                gate[sel_q]                          <= 1'b1;
                                gate_chgd[sel_q]                     <= 1'b1;
                                voice_note[sel_q*NOTE_W +: NOTE_W]   <= note_q;
                                state                                <= ST_TRIG;
                            end
                            PATH_KILL: begin
                                gate[sel_q] <= 1'b0;
                                steal       <= steal_q;
                                state       <= ST_KILL;
                            end
                            PATH_OFF: begin
                                gate[sel_q] <= 1'b0;
                                state       <= ST_IDLE;
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_KILL: begin
                    gate[sel_q]                        <= 1'b1;
                    gate_chgd[sel_q]                   <= 1'b1;
                    voice_note[sel_q*NOTE_W +: NOTE_W] <= note_q;
                    steal                              <= 1'b0;
                    state                              <= ST_TRIG;
                end
                default: begin
                    gate_chgd <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ncf_voice_alloc.sv
// Scoreboard bench for ncf_voice_alloc: the driver queues the expected output
// events and busy lengths, the monitor pops and compares them.
module tb_ncf_voice_alloc;

    logic        clock;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_on;
    logic [6:0]  cmd_note;
    logic [3:0]  env_idle;
    logic [3:0]  gate;
    logic [3:0]  gate_chgd;
    logic [27:0] voice_note;
    logic        steal;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc   = 0;

    typedef struct {
        logic [3:0]  g;
        logic [3:0]  c;
        logic        s;
        logic [27:0] vn;
        int          dly;
    } snap_t;

    snap_t exp_q[$];
    int    lat_q[$];

    ncf_voice_alloc #(
        .NUM_VOICES (4),
        .NOTE_W     (7)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_on     (cmd_on),
        .cmd_note   (cmd_note),
        .env_idle   (env_idle),
        .gate       (gate),
        .gate_chgd  (gate_chgd),
        .voice_note (voice_note),
        .steal      (steal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [27:0] vn(input logic [6:0] n3, input logic [6:0] n2,
                                       input logic [6:0] n1, input logic [6:0] n0);
        return {n3, n2, n1, n0};
    endfunction

    task automatic exp_ev(input logic [3:0] g, input logic [3:0] c, input logic s,
                          input logic [27:0] v, input int dly);
        snap_t e;
        e.g = g; e.c = c; e.s = s; e.vn = v; e.dly = dly;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic on, input logic [6:0] n, input logic [3:0] idle);
        int k;
        k = 0;
        @(negedge clock);
        while (!cmd_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout note=%0d got ready=%b want 1", n, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_on    = on;
        cmd_note  = n;
        env_idle  = idle;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic settle();
        int k;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic fill4();
        send(1'b1, 7'd60, 4'hF);
        send(1'b1, 7'd62, 4'hF);
        send(1'b1, 7'd64, 4'hF);
        send(1'b1, 7'd67, 4'hF);
    endtask

    task automatic exp_fill4();
        exp_ev(4'b0001, 4'b0001, 1'b0, vn(0, 0, 0, 60), 2);
        exp_ev(4'b0001, 4'b0000, 1'b0, vn(0, 0, 0, 60), 3);
        lat_q.push_back(3);
        exp_ev(4'b0011, 4'b0010, 1'b0, vn(0, 0, 62, 60), 2);
        exp_ev(4'b0011, 4'b0000, 1'b0, vn(0, 0, 62, 60), 3);
        lat_q.push_back(3);
        exp_ev(4'b0111, 4'b0100, 1'b0, vn(0, 64, 62, 60), 2);
        exp_ev(4'b0111, 4'b0000, 1'b0, vn(0, 64, 62, 60), 3);
        lat_q.push_back(3);
        exp_ev(4'b1111, 4'b1000, 1'b0, vn(67, 64, 62, 60), 2);
        exp_ev(4'b1111, 4'b0000, 1'b0, vn(67, 64, 62, 60), 3);
        lat_q.push_back(3);
    endtask

    // Accept-edge bookkeeping for event timing
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            if (reset_n && cmd_valid && cmd_ready) acc = cyc;
        end
    end

    // Monitor: every output change pops one expected event; every busy
    // stretch of cmd_ready pops one expected length
    initial begin
        logic [3:0]  pg, pc;
        logic        ps;
        logic [27:0] pvn;
        int          busy;
        snap_t       e;
        pg = '0; pc = '0; ps = 1'b0; pvn = '0; busy = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pg = gate; pc = gate_chgd; ps = steal; pvn = voice_note;
                busy = 0;
            end else begin
                if (gate !== pg || gate_chgd !== pc || steal !== ps || voice_note !== pvn) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_event got gate=%b chgd=%b steal=%b vn=%h want no change",
                                 gate, gate_chgd, steal, voice_note);
                    end else begin
                        e = exp_q.pop_front();
                        if (gate !== e.g || gate_chgd !== e.c || steal !== e.s ||
                            voice_note !== e.vn || (cyc - acc) != e.dly) begin
                            bad++;
                            $display("FAIL out_event got gate=%b chgd=%b steal=%b vn=%h at E%0d want gate=%b chgd=%b steal=%b vn=%h at E%0d",
                                     gate, gate_chgd, steal, voice_note, cyc - acc,
                                     e.g, e.c, e.s, e.vn, e.dly);
                        end
                    end
                    pg = gate; pc = gate_chgd; ps = steal; pvn = voice_note;
                end
                if (!cmd_ready) begin
                    busy++;
                end else if (busy > 0) begin
                    total++;
                    if (lat_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_busy got=%0d want none", busy);
                    end else if (lat_q[0] != busy) begin
                        bad++;
                        $display("FAIL busy_len got=%0d want=%0d", busy, lat_q[0]);
                        void'(lat_q.pop_front());
                    end else begin
                        void'(lat_q.pop_front());
                    end
                    busy = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_on    = 1'b0;
        cmd_note  = '0;
        env_idle  = 4'hF;
        repeat (2) @(negedge clock);
        chk("rst_gate",  32'(gate), 32'h0);
        chk("rst_chgd",  32'(gate_chgd), 32'h0);
        chk("rst_vn",    32'(voice_note), 32'h0);
        chk("rst_steal", 32'(steal), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        reset_n = 1'b1;

        // Fill all four voices, steal the oldest, then reuse and release paths
        exp_fill4();
        fill4();
        exp_ev(4'b1110, 4'b0000, 1'b1, vn(67, 64, 62, 60), 2);
        exp_ev(4'b1111, 4'b0001, 1'b0, vn(67, 64, 62, 72), 3);
        exp_ev(4'b1111, 4'b0000, 1'b0, vn(67, 64, 62, 72), 4);
        lat_q.push_back(4);
        send(1'b1, 7'd72, 4'hF);
        exp_ev(4'b1101, 4'b0000, 1'b0, vn(67, 64, 62, 72), 2);
        lat_q.push_back(2);
        send(1'b0, 7'd62, 4'h0);
        exp_ev(4'b1111, 4'b0010, 1'b0, vn(67, 64, 62, 72), 2);
        exp_ev(4'b1111, 4'b0000, 1'b0, vn(67, 64, 62, 72), 3);
        lat_q.push_back(3);
        send(1'b1, 7'd62, 4'h0);
        exp_ev(4'b1011, 4'b0000, 1'b0, vn(67, 64, 62, 72), 2);
        lat_q.push_back(2);
        send(1'b0, 7'd64, 4'h0);
        exp_ev(4'b0011, 4'b0000, 1'b0, vn(67, 64, 62, 72), 2);
        lat_q.push_back(2);
        send(1'b0, 7'd67, 4'h0);
        exp_ev(4'b0111, 4'b0100, 1'b0, vn(67, 70, 62, 72), 2);
        exp_ev(4'b0111, 4'b0000, 1'b0, vn(67, 70, 62, 72), 3);
        lat_q.push_back(3);
        send(1'b1, 7'd70, 4'h0);
        settle();

        // Same note twice: retrigger through KILL without steal
        do_reset();
        exp_ev(4'b0001, 4'b0001, 1'b0, vn(0, 0, 0, 60), 2);
        exp_ev(4'b0001, 4'b0000, 1'b0, vn(0, 0, 0, 60), 3);
        lat_q.push_back(3);
        send(1'b1, 7'd60, 4'hF);
        exp_ev(4'b0000, 4'b0000, 1'b0, vn(0, 0, 0, 60), 2);
        exp_ev(4'b0001, 4'b0001, 1'b0, vn(0, 0, 0, 60), 3);
        exp_ev(4'b0001, 4'b0000, 1'b0, vn(0, 0, 0, 60), 4);
        lat_q.push_back(4);
        send(1'b1, 7'd60, 4'hF);
        settle();

        // Idle voice preferred over a releasing one; unmatched note-off dropped
        do_reset();
        exp_ev(4'b0001, 4'b0001, 1'b0, vn(0, 0, 0, 60), 2);
        exp_ev(4'b0001, 4'b0000, 1'b0, vn(0, 0, 0, 60), 3);
        lat_q.push_back(3);
        send(1'b1, 7'd60, 4'hF);
        exp_ev(4'b0000, 4'b0000, 1'b0, vn(0, 0, 0, 60), 2);
        lat_q.push_back(2);
        send(1'b0, 7'd60, 4'b1110);
        exp_ev(4'b0010, 4'b0010, 1'b0, vn(0, 0, 65, 60), 2);
        exp_ev(4'b0010, 4'b0000, 1'b0, vn(0, 0, 65, 60), 3);
        lat_q.push_back(3);
        send(1'b1, 7'd65, 4'b1110);
        lat_q.push_back(2);
        send(1'b0, 7'd50, 4'b1110);
        settle();

        // Reset during KILL of a steal, then ranks must be back to identity
        do_reset();
        exp_fill4();
        fill4();
        exp_ev(4'b1110, 4'b0000, 1'b1, vn(67, 64, 62, 60), 2);
        send(1'b1, 7'd72, 4'hF);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("kill_rst_gate",  32'(gate), 32'h0);
        chk("kill_rst_chgd",  32'(gate_chgd), 32'h0);
        chk("kill_rst_ready", 32'(cmd_ready), 32'h1);
        chk("kill_rst_steal", 32'(steal), 32'h0);
        chk("kill_rst_vn",    32'(voice_note), 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        exp_ev(4'b1000, 4'b1000, 1'b0, vn(80, 0, 0, 0), 2);
        exp_ev(4'b1000, 4'b0000, 1'b0, vn(80, 0, 0, 0), 3);
        lat_q.push_back(3);
        send(1'b1, 7'd80, 4'h0);
        settle();

        k = 0;
        while ((exp_q.size() != 0 || lat_q.size() != 0) && k < 10) begin
            @(negedge clock);
            k++;
        end
        total++;
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got events=%0d busy=%0d want 0 0", exp_q.size(), lat_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ncf_voice_alloc.md
# ncf_voice_alloc

Polyphonic voice allocator that shares a bank of `NUM_VOICES` ADSR envelope generators (NCA/NCF `GATE`/`GATEchgd` interface) between incoming note-on/note-off commands. It sits between the MIDI note decoder and the per-voice ADSR instances. It chooses a voice per note: free first, then releasing, then stealing the least-recently-triggered voice. It drives each voice's `gate`/`gate_chgd` so that the ADSR (re)enters ATTACK from any state, including SUSTAIN.

## Interface
- `NUM_VOICES`, 4, number of ADSR voices, 2..16.
- `NOTE_W`, 7, note-number width.
- `clock` in 1: single clock, 50 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in FSM state IDLE.
- `cmd_on` in 1: 1 = note-on, 0 = note-off.
- `cmd_note` in NOTE_W: note number.
- `env_idle` in NUM_VOICES: per-voice ADSR in IDLE state (state == 0).
- `gate` out NUM_VOICES: per-voice GATE.
- `gate_chgd` out NUM_VOICES: per-voice GATEchgd, single-cycle pulse.
- `voice_note` out NUM_VOICES*NOTE_W: note held by each voice; voice v occupies bits [v*NOTE_W +: NOTE_W].
- `steal` out 1: one-cycle pulse when a gated voice is stolen.

## Operation
- Reset values: `gate`=0, `gate_chgd`=0, `voice_note`=0, `steal`=0, FSM=IDLE (`cmd_ready`=1), rank[v]=v.
- Handshake: a command is accepted on an edge with `cmd_valid & cmd_ready`. `cmd_note`/`cmd_on` are latched at that edge. Exactly one command is in flight.
- FSM states are IDLE, SCAN, KILL and TRIG.
  - IDLE goes to SCAN on accept.
  - SCAN evaluates the latched command against the registered voice state and latches the selected voice `sel` and the path.
  - KILL forces `gate[sel]`=0 for one cycle, then goes to TRIG.
  - TRIG sets `gate[sel]`=1, `gate_chgd[sel]`=1, `voice_note[sel]`=note, updates LRU, then goes to IDLE.
- Note-on selection priority, first hit wins; "lowest index" breaks ties:
  1. Voice with matching note and gate=1: path KILL→TRIG (retrigger; needed because ADSR SUSTAIN ignores GATEchgd).
  2. Voice with matching note and gate=0: path TRIG.
  3. Lowest-index voice with gate=0 and env_idle=1: path TRIG.
  4. Highest-rank voice with gate=0 (releasing): path TRIG.
  5. Highest-rank voice (all gated): path KILL→TRIG, and `steal` pulses in the KILL cycle.
- Note-off: the lowest-index voice with matching note and gate=1 gets `gate`=0 at SCAN exit, then the FSM returns to IDLE. With no match the command is dropped and the FSM returns to IDLE with no output change.
- LRU: rank is a permutation of 0..N-1, where 0 is the newest. On TRIG of v, every voice with rank < rank[v] increments, and rank[v] becomes 0.
- `gate_chgd` is never high unless the same voice's `gate` is high in the same cycle.
- Reset mid-operation: all gates drop immediately (async), and the in-flight command is lost.

## Timing
- E0 is the accept edge. In SCAN the selection registers at E1.
- TRIG path: `gate`↑ and `gate_chgd`↑ at E2; `gate_chgd`↓ and `cmd_ready`↑ at E3.
- KILL path: `gate`↓ (and `steal`↑ if stolen) at E2; `gate`↑, `gate_chgd`↑ and `steal`↓ at E3; `gate_chgd`↓ and `cmd_ready`↑ at E4.
- Note-off: `gate`↓ and `cmd_ready`↑ at E2.
- Throughput: 3 cycles per TRIG note-on, 4 per KILL, 2 per note-off.
- `env_idle` is sampled only in SCAN; changes at other times have no effect.

## Structure
- `ncf_voice_pkg` holds:
  - the FSM state enum (IDLE=0, SCAN=1, KILL=2, TRIG=3);
  - the path encoding;
  - the `NOTE_W` default.
- Sub-module `ncf_lru_rank` holds the NUM_VOICES rank registers, touch(v), and an oldest-index output (pure ranking, no note logic).
- Top level holds the FSM, the priority encoders, and the gate/note registers.

## Test plan
- Reset, then note-on 60 with `env_idle`=4'hF → voice 0: `gate`=4'b0001 at E2, `gate_chgd`=4'b0001 for exactly one cycle, `voice_note[0]`=60, `cmd_ready` back at E3.
- Note-on 60, 62, 64, 67, then note-on 72 with all gated → rank-oldest voice 0: `steal` pulse, `gate[0]` low one cycle at E2, high with `gate_chgd[0]` at E3, `voice_note[0]`=72.
- Note-on 60, then note-on 60 again → same voice: KILL/TRIG sequence, no `steal`, `voice_note` unchanged.
- Note-on 60 (v0), note-off 60 with `env_idle[0]`=0, then note-on 65 with `env_idle`=4'b1110 → v1 chosen (idle before releasing).
- Note-off 50 with no voice holding it → no output change, `cmd_ready` back at E2.
- `reset_n` asserted during KILL → `gate`=0, `gate_chgd`=0, `cmd_ready`=1 asynchronously; ranks back to v.
